float_divider_bf16: RTL and testbench

- Sequential bfloat16 divider, y = a / b, for the arithmetic datapath.
- It is the inverse operation of the team's bf16 multiplier and uses the same operand format, sign/exponent/mantissa split and bias of 127.
- Mantissa quotient is formed by iterative restoring division, one quotient bit per cycle, followed by normalize and round-to-nearest-even stages.
- Start/busy/valid handshake; one operation in flight at a time.

---
 rtl/float_divider_bf16.sv | 146 ++++++++++++++
 tb/tb_float_divider_bf16.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/float_divider_bf16.sv
// rtl/float_divider_bf16.sv - sequential bfloat16 divider (restoring mantissa division, RNE rounding)
module float_divider_bf16 #(
    parameter int BIAS  = 127,
    parameter int QBITS = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic [15:0] y,
    output logic        is_output_valid,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, ROUND} state_t;

    state_t state, state_next;

    logic              sign;
    logic signed [9:0] exp_t;
    logic        [9:0] rem;
    logic        [8:0] div;
    logic  [QBITS-1:0] q;
    logic        [3:0] cnt;
    logic        [6:0] man;
    logic              g;
    logic              s;

    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, special, res_sign;
    logic [15:0] spec_y;
    logic        spec_dz;

    assign a_nan    = (&a[14:7]) & (|a[6:0]);
    assign a_inf    = (&a[14:7]) & ~(|a[6:0]);
    assign a_zero   = ~(|a[14:7]);
    assign b_nan    = (&b[14:7]) & (|b[6:0]);
    assign b_inf    = (&b[14:7]) & ~(|b[6:0]);
    assign b_zero   = ~(|b[14:7]);
    assign special  = (&a[14:7]) | (&b[14:7]) | a_zero | b_zero;
    assign res_sign = a[15] ^ b[15];

    always_comb begin
        spec_y  = {res_sign, 15'h0};
        spec_dz = 1'b0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_y = 16'h7FC0;
        end else if (b_zero) begin
            spec_y  = {res_sign, 8'hFF, 7'h0};
            spec_dz = ~a_inf;
        end else if (a_inf) begin
            spec_y = {res_sign, 8'hFF, 7'h0};
        end
    end

    // One restoring-division step; rem stays below 2*div so 10 bits suffice.
    logic       ge;
    logic [9:0] rem_next;
    assign ge       = rem >= {1'b0, div};
    assign rem_next = ge ? ((rem - {1'b0, div}) << 1) : (rem << 1);

    logic              round_up, carry;
    logic        [6:0] man_r;
    logic signed [9:0] exp_r;
    assign round_up      = g & (s | man[0]);
    assign {carry, man_r} = {1'b0, man} + {7'h0, round_up};
    assign exp_r         = exp_t + $signed({9'h0, carry});

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !special) state_next = DIV;
            DIV:     if (cnt == 4'(QBITS - 1)) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y               <= 16'h0;
            is_output_valid <= 1'b0;
            div_by_zero     <= 1'b0;
            sign            <= 1'b0;
            exp_t           <= 10'sd0;
            rem             <= 10'h0;
            div             <= 9'h0;
            q               <= '0;
            cnt             <= 4'h0;
            man             <= 7'h0;
            g               <= 1'b0;
            s               <= 1'b0;
        end else begin
            is_output_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (special) begin
                        y               <= spec_y;
                        div_by_zero     <= spec_dz;
                        is_output_valid <= 1'b1;
                    end else begin
                        sign  <= res_sign;
                        exp_t <= {2'b0, a[14:7]} - {2'b0, b[14:7]} + 10'(BIAS);
                        rem   <= {2'b01, a[6:0]};
                        div   <= {2'b01, b[6:0]};
                        cnt   <= 4'h0;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    q   <= {q[QBITS-2:0], ge};
                    cnt <= cnt + 4'h1;
                end
                NORM: begin
                    // Quotient ratio is in (0.5,2): either the integer bit is set or the next one is.
                    if (q[10]) begin
                        man <= q[9:3];
                        g   <= q[2];
                        s   <= (|q[1:0]) | (|rem);
                    end else begin
                        exp_t <= exp_t - 10'sd1;
                        man   <= q[8:2];
                        g     <= q[1];
                        s     <= q[0] | (|rem);
                    end
                end
                ROUND: begin
                    if (exp_r >= 10'sd255)   y <= {sign, 8'hFF, 7'h0};
                    else if (exp_r <= 10'sd0) y <= {sign, 15'h0};
                    else                     y <= {sign, exp_r[7:0], man_r};
                    div_by_zero     <= 1'b0;
                    is_output_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_divider_bf16.sv
// tb/tb_float_divider_bf16.sv - randomized self-checking bench for float_divider_bf16
module tb_float_divider_bf16;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        busy;
    logic [15:0] y;
    logic        is_output_valid;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    float_divider_bf16 dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .y(y), .is_output_valid(is_output_valid), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Reference: exact integer quotient of the significands with round-half-even.
    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb);
        int ae, be, am, bm, num, den, qq, r, e;
        logic sg, an, bn, ai, bi, az, bz;
        ae = int'(ma[14:7]); be = int'(mb[14:7]);
        am = int'(ma[6:0]);  bm = int'(mb[6:0]);
        sg = ma[15] ^ mb[15];
        an = (ae == 255) && (am != 0); bn = (be == 255) && (bm != 0);
        ai = (ae == 255) && (am == 0); bi = (be == 255) && (bm == 0);
        az = (ae == 0);                bz = (be == 0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 16'h7FC0};
        if (bz) return {!ai, sg, 8'hFF, 7'h0};
        if (ai) return {1'b0, sg, 8'hFF, 7'h0};
        if (az || bi) return {1'b0, sg, 15'h0};
        num = 128 + am; den = 128 + bm; e = ae - be + 127;
        if (num >= den) begin
            qq = (num * 128) / den; r = (num * 128) % den;
        end else begin
            e = e - 1; qq = (num * 256) / den; r = (num * 256) % den;
        end
        if ((2 * r > den) || ((2 * r == den) && (qq % 2 == 1))) qq = qq + 1;
        if (qq == 256) begin qq = 128; e = e + 1; end
        if (e >= 255) return {1'b0, sg, 8'hFF, 7'h0};
        if (e <= 0)   return {1'b0, sg, 15'h0};
        return {1'b0, sg, 8'(e), 7'(qq)};
    endfunction

    function automatic bit is_special(input logic [15:0] ma, input logic [15:0] mb);
        return (ma[14:7] == 8'h00) || (ma[14:7] == 8'hFF) || (mb[14:7] == 8'h00) || (mb[14:7] == 8'hFF);
    endfunction

    // Runs one operation; lat = edges after the accepting edge until valid is seen, bcnt = busy samples.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_in, output logic [15:0] ry,
                         output logic rdz, output int lat, output int bcnt, output bit single);
        @(negedge clock);
        a = ta; b = tb_in; start = 1'b1;
        @(negedge clock);
        start = 1'b0; lat = 0; bcnt = 0;
        while (!is_output_valid && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clock);
            lat++;
        end
        ry = y; rdz = div_by_zero;
        @(negedge clock);
        single = !is_output_valid;
    endtask

    task automatic test_reset;
        total++; if (y !== 16'h0) begin bad++; $display("FAIL reset_y got=%h exp=0000", y); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (is_output_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", is_output_valid); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] ry; logic rdz; int lat, bcnt; bit single;
        do_op(16'h4040, 16'h4000, ry, rdz, lat, bcnt, single);
        total++; if (ry !== 16'h3FC0) begin bad++; $display("FAIL basic_y got=%h exp=3fc0", ry); end
        total++; if (rdz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b exp=0", rdz); end
        total++; if (lat != 13) begin bad++; $display("FAIL basic_latency got=%0d exp=13", lat); end
        total++; if (bcnt != 13) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=13", bcnt); end
        total++; if (!single) begin bad++; $display("FAIL basic_pulse got=wide exp=one_cycle"); end
    endtask

    task automatic test_rounding;
        logic [15:0] ry; logic rdz; int lat, bcnt; bit single;
        do_op(16'h3F80, 16'h4040, ry, rdz, lat, bcnt, single);
        total++; if (ry !== 16'h3EAB) begin bad++; $display("FAIL round_pos got=%h exp=3eab", ry); end
        do_op(16'hBF80, 16'h4040, ry, rdz, lat, bcnt, single);
        total++; if (ry !== 16'hBEAB) begin bad++; $display("FAIL round_neg got=%h exp=beab", ry); end
    endtask

    task automatic test_special;
        logic [15:0] ta [8] = '{16'hC000, 16'h0000, 16'h7FC1, 16'h0000, 16'h3F80, 16'h7F00, 16'h0080, 16'h0001};
        logic [15:0] tb2[8] = '{16'h0000, 16'h0000, 16'h3F80, 16'h4000, 16'h7F80, 16'h3E80, 16'h4000, 16'h3F80};
        logic [15:0] ey [8] = '{16'hFF80, 16'h7FC0, 16'h7FC0, 16'h0000, 16'h0000, 16'h7F80, 16'h0000, 16'h0000};
        logic        ed [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          el [8] = '{0, 0, 0, 0, 0, 13, 13, 0};
        logic [15:0] ry; logic rdz; int lat, bcnt; bit single;
        for (int i = 0; i < 8; i++) begin
            do_op(ta[i], tb2[i], ry, rdz, lat, bcnt, single);
            total++; if (ry !== ey[i]) begin bad++; $display("FAIL special_y[%0d] got=%h exp=%h", i, ry, ey[i]); end
            total++; if (rdz !== ed[i]) begin bad++; $display("FAIL special_dz[%0d] got=%b exp=%b", i, rdz, ed[i]); end
            total++; if (lat != el[i]) begin bad++; $display("FAIL special_lat[%0d] got=%0d exp=%0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] ry; logic rdz; int lat, bcnt; bit single, seen;
        @(negedge clock); a = 16'h4040; b = 16'h4000; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (y !== 16'h0) begin bad++; $display("FAIL midreset_y got=%h exp=0000", y); end
        @(negedge clock); reset = 1'b0; seen = 0;
        repeat (20) begin @(negedge clock); if (is_output_valid) seen = 1; end
        total++; if (seen) begin bad++; $display("FAIL midreset_no_valid got=1 exp=0"); end
        do_op(16'h4040, 16'h4000, ry, rdz, lat, bcnt, single);
        total++; if (ry !== 16'h3FC0 || lat != 13) begin
            bad++; $display("FAIL midreset_after got=%h/%0d exp=3fc0/13", ry, lat);
        end
    endtask

    task automatic test_back_to_back;
        int t[3]; logic [15:0] yy[3]; int n = 0, cyc = 0, dbl = 0; bit prev = 0;
        @(negedge clock); a = 16'h4040; b = 16'h4000; start = 1'b1;
        while (n < 3 && cyc < 100) begin
            @(negedge clock); cyc++;
            if (is_output_valid) begin
                if (prev) dbl++;
                t[n] = cyc; yy[n] = y; n++;
            end
            prev = is_output_valid;
            if (busy) begin a = 16'($urandom); b = 16'($urandom); end
            else      begin a = 16'h4040; b = 16'h4000; end
        end
        start = 1'b0;
        total++; if (n != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", n); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (yy[i] !== 16'h3FC0) begin bad++; $display("FAIL b2b_y[%0d] got=%h exp=3fc0", i, yy[i]); end
            end
            total++; if (t[1] - t[0] != 14 || t[2] - t[1] != 14) begin
                bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=14,14", t[1] - t[0], t[2] - t[1]);
            end
        end
        total++; if (dbl != 0) begin bad++; $display("FAIL b2b_pulse got=%0d exp=0", dbl); end
        repeat (16) @(negedge clock);
    endtask

    task automatic test_random;
        logic [15:0] ra, rb, ry; logic rdz; logic [16:0] exp_v; int lat, bcnt; bit single;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra[14:7] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 7) == 0) rb[14:7] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 3) == 0) ra[14:7] = 8'(120 + $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb[14:7] = 8'(120 + $urandom_range(0, 15));
            exp_v = model(ra, rb);
            do_op(ra, rb, ry, rdz, lat, bcnt, single);
            total++; if (ry !== exp_v[15:0] || rdz !== exp_v[16]) begin
                bad++; $display("FAIL random %h/%h got=%h,%b exp=%h,%b", ra, rb, ry, rdz, exp_v[15:0], exp_v[16]);
            end
            total++; if (lat != (is_special(ra, rb) ? 0 : 13) || !single) begin
                bad++; $display("FAIL random_lat %h/%h got=%0d,%0d", ra, rb, lat, single);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset;
        test_basic;
        test_rounding;
        test_special;
        test_mid_reset;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
